// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// Receives 8-bit LSB-first UART characters (optionally followed by a parity
// bit) and packs NUM_BYTES of them into one frame word. The finished frame is
// offered with a DATA_READY / DATA_RETRIEVED handshake.
//
// Ports:
//   CLK            system clock
//   RST_N          asynchronous active-low reset
//   RX             serial line, idle high, asynchronous to CLK
//   DATA_RETRIEVED consumer has taken DATA (level or pulse); also clears errors
//   DATA_READY     frame valid, held until retrieved
//   DATA           byte k at DATA[8k+7:8k], byte 0 received first
//   ERR_FRAME      sticky: stop bit sampled low
//   ERR_PARITY     sticky: parity mismatch
//   ERR_OVERRUN    sticky: start edge seen while a frame was waiting
//   ERR_TIMEOUT    sticky: partial frame dropped after too long an idle gap
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   RX,
    input  logic                   DATA_RETRIEVED,
    output logic                   DATA_READY,
    output logic [8*NUM_BYTES-1:0] DATA,
    output logic                   ERR_FRAME,
    output logic                   ERR_PARITY,
    output logic                   ERR_OVERRUN,
    output logic                   ERR_TIMEOUT
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int BC_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NUM_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_ABORT  = 3'd5,
        ST_HOLD   = 3'd6
    } state_t;

    // True when the data bits plus the received parity bit give the wanted parity.
    function automatic logic parity_ok(input logic [7:0] d, input logic p, input logic odd);
        return ((^d) ^ p) == odd;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [1:0]             sync_r;
    logic                   rx_s, rx_prev_r;
    logic [CNT_W-1:0]       clk_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [BC_W-1:0]        byte_cnt_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic [7:0]             shift_r;
    logic [8*NUM_BYTES-1:0] data_r;
    logic                   ready_r;
    logic                   err_frame_r, err_parity_r, err_overrun_r, err_timeout_r;

    logic cnt_clr_s, shift_en_s, byte_wr_s, byte_clr_s, byte_last_s;
    logic set_frame_s, set_parity_s, set_overrun_s, set_timeout_s, tmo_hit_s;

    assign rx_s        = sync_r[1];
    assign byte_last_s = (byte_cnt_r == BC_LAST);
    assign tmo_hit_s   = (TIMEOUT_BITS != 0) && (byte_cnt_r != {BC_W{1'b0}}) && (tmo_cnt_r == TMO_LAST);
    // A falling edge while a frame waits is a character we cannot accept.
    assign set_overrun_s = (state_r == ST_HOLD) && rx_prev_r && !rx_s;

    // Next-state and control strobes for the receive sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_clr_s     = 1'b0;
        shift_en_s    = 1'b0;
        byte_wr_s     = 1'b0;
        byte_clr_s    = 1'b0;
        set_frame_s   = 1'b0;
        set_parity_s  = 1'b0;
        set_timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = ST_START;
                    cnt_clr_s   = 1'b1;
                end else if (tmo_hit_s) begin
                    byte_clr_s    = 1'b1;
                    set_timeout_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Start bit must stay low up to its midpoint; anything shorter is a glitch.
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (clk_cnt_r == HALF_END) begin
                    state_nxt_s = ST_DATA;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == BIT_END) begin
                    shift_en_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (clk_cnt_r == BIT_END) begin
                    cnt_clr_s = 1'b1;
                    if (parity_ok(shift_r, rx_s, ODD_BIT)) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        set_parity_s = 1'b1;
                        byte_clr_s   = 1'b1;
                        state_nxt_s  = ST_ABORT;
                    end
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (clk_cnt_r == BIT_END) begin
                    cnt_clr_s = 1'b1;
                    if (!rx_s) begin
                        set_frame_s = 1'b1;
                        byte_clr_s  = 1'b1;
                        state_nxt_s = ST_ABORT;
                    end else begin
                        byte_wr_s   = 1'b1;
                        state_nxt_s = byte_last_s ? ST_HOLD : ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_ABORT: begin
                // Need a full bit time of idle so a long break is not read as a start.
                if (!rx_s) begin
                    cnt_clr_s = 1'b1;
                end else if (clk_cnt_r == BIT_END) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
            ST_HOLD: begin
                if (DATA_RETRIEVED) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Input synchroniser, edge history and state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
            state_r   <= ST_IDLE;
        end else begin
            sync_r    <= {sync_r[0], RX};
            rx_prev_r <= rx_s;
            state_r   <= state_nxt_s;
        end
    end

    // Bit-period clock counter (saturating) and idle timeout counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_cnt_r <= {CNT_W{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            if (cnt_clr_s) begin
                clk_cnt_r <= {CNT_W{1'b0}};
            end else if (clk_cnt_r != BIT_END) begin
                clk_cnt_r <= clk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                clk_cnt_r <= clk_cnt_r;
            end
            if ((state_r == ST_IDLE) && (byte_cnt_r != {BC_W{1'b0}})) begin
                if (tmo_cnt_r != TMO_LAST) begin
                    tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end else begin
                    tmo_cnt_r <= tmo_cnt_r;
                end
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
        end
    end

    // Shift register, bit and byte counters, frame storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= {BC_W{1'b0}};
            data_r     <= {(8*NUM_BYTES){1'b0}};
        end else begin
            if (shift_en_s) begin
                shift_r   <= {rx_s, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                shift_r   <= shift_r;
                bit_cnt_r <= bit_cnt_r;
            end
            if (byte_clr_s || (byte_wr_s && byte_last_s)) begin
                byte_cnt_r <= {BC_W{1'b0}};
            end else if (byte_wr_s) begin
                byte_cnt_r <= byte_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (byte_wr_s && (byte_cnt_r == BC_W'(k))) begin
                    data_r[8*k +: 8] <= shift_r;
                end else begin
                    data_r[8*k +: 8] <= data_r[8*k +: 8];
                end
            end
        end
    end

    // Ready flag and sticky error flags; a set beats a same-cycle clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_r       <= 1'b0;
            err_frame_r   <= 1'b0;
            err_parity_r  <= 1'b0;
            err_overrun_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            ready_r       <= (state_nxt_s == ST_HOLD);
            err_frame_r   <= set_frame_s   | (err_frame_r   & ~DATA_RETRIEVED);
            err_parity_r  <= set_parity_s  | (err_parity_r  & ~DATA_RETRIEVED);
            err_overrun_r <= set_overrun_s | (err_overrun_r & ~DATA_RETRIEVED);
            err_timeout_r <= set_timeout_s | (err_timeout_r & ~DATA_RETRIEVED);
        end
    end

    assign DATA_READY  = ready_r;
    assign DATA        = data_r;
    assign ERR_FRAME   = err_frame_r;
    assign ERR_PARITY  = err_parity_r;
    assign ERR_OVERRUN = err_overrun_r;
    assign ERR_TIMEOUT = err_timeout_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame: 16 clocks per bit, 2-byte frames, even parity,
// 4-bit-period inter-byte timeout. Expected frames go into a scoreboard queue
// as they are sent and are compared when DATA_READY rises.
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int NB  = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          RX = 1'b1;
    logic          DATA_RETRIEVED = 1'b0;
    logic          DATA_READY;
    logic [8*NB-1:0] DATA;
    logic          ERR_FRAME, ERR_PARITY, ERR_OVERRUN, ERR_TIMEOUT;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [15:0]   exp_q[$];
    logic          rdy_prev = 1'b0;

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES(NB),
        .PARITY_EN(1),
        .PARITY_ODD(0),
        .TIMEOUT_BITS(4)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .RX(RX),
        .DATA_RETRIEVED(DATA_RETRIEVED),
        .DATA_READY(DATA_READY),
        .DATA(DATA),
        .ERR_FRAME(ERR_FRAME),
        .ERR_PARITY(ERR_PARITY),
        .ERR_OVERRUN(ERR_OVERRUN),
        .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: each rising DATA_READY consumes one expected frame.
    always @(negedge CLK) begin
        if (DATA_READY && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_frame", 64'(DATA), 64'hDEAD);
            end else begin
                check_eq("frame_data", 64'(DATA), 64'(exp_q.pop_front()));
            end
        end
        rdy_prev <= DATA_READY;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        idle(CPB);
    endtask

    // One character: start, 8 data LSB first, even parity (optionally wrong), stop.
    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop_val);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ bad_par);
        send_bit(stop_val);
        RX = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!DATA_READY && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, 64'(DATA_READY), 64'd1);
    endtask

    task automatic retrieve(input string tag);
        @(negedge CLK);
        DATA_RETRIEVED = 1'b1;
        @(negedge CLK);
        DATA_RETRIEVED = 1'b0;
        check_eq(tag, 64'(DATA_READY), 64'd0);
    endtask

    function automatic logic [63:0] errs();
        return 64'({ERR_FRAME, ERR_PARITY, ERR_OVERRUN, ERR_TIMEOUT});
    endfunction

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        check_eq("rst_ready", 64'(DATA_READY), 64'd0);
        check_eq("rst_data", 64'(DATA), 64'd0);
        check_eq("rst_errs", errs(), 64'd0);
        RST_N = 1'b1;
        idle(5);

        // Normal back-to-back frame
        exp_q.push_back(16'h3CA5);
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);
        wait_ready("normal_ready");
        check_eq("normal_errs", errs(), 64'd0);
        retrieve("normal_retrieved");

        // Glitch on RX, then a good frame proves byte count is untouched
        RX = 1'b0;
        idle(5);
        RX = 1'b1;
        idle(40);
        check_eq("glitch_ready", 64'(DATA_READY), 64'd0);
        check_eq("glitch_errs", errs(), 64'd0);
        exp_q.push_back(16'h1234);
        send_byte(8'h34, 1'b0, 1'b1);
        send_byte(8'h12, 1'b0, 1'b1);
        wait_ready("glitch_frame_ready");
        retrieve("glitch_retrieved");

        // Framing error followed by recovery
        send_byte(8'h11, 1'b0, 1'b0);
        idle(32);
        check_eq("frame_err", errs(), 64'b1000);
        check_eq("frame_err_ready", 64'(DATA_READY), 64'd0);
        exp_q.push_back(16'h0201);
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 1'b1);
        wait_ready("frame_recover_ready");
        check_eq("frame_err_sticky", errs(), 64'b1000);
        retrieve("frame_retrieved");
        check_eq("frame_err_cleared", errs(), 64'd0);

        // Parity: good 0x07 accepted
        exp_q.push_back(16'h0807);
        send_byte(8'h07, 1'b0, 1'b1);
        send_byte(8'h08, 1'b0, 1'b1);
        wait_ready("parity_good_ready");
        check_eq("parity_good_errs", errs(), 64'd0);
        retrieve("parity_good_retrieved");

        // Parity: bad 0x07 as second byte restarts the frame at byte 0
        send_byte(8'h09, 1'b0, 1'b1);
        send_byte(8'h07, 1'b1, 1'b1);
        idle(24);
        check_eq("parity_err", errs(), 64'b0100);
        check_eq("parity_err_ready", 64'(DATA_READY), 64'd0);
        exp_q.push_back(16'h4321);
        send_byte(8'h21, 1'b0, 1'b1);
        send_byte(8'h43, 1'b0, 1'b1);
        wait_ready("parity_recover_ready");
        retrieve("parity_retrieved");

        // Timeout: one byte, short idle is fine, long idle drops it
        send_byte(8'h5A, 1'b0, 1'b1);
        idle(20);
        check_eq("timeout_early", errs(), 64'd0);
        idle(60);
        check_eq("timeout_err", errs(), 64'b0001);
        check_eq("timeout_ready", 64'(DATA_READY), 64'd0);
        exp_q.push_back(16'h7766);
        send_byte(8'h66, 1'b0, 1'b1);
        send_byte(8'h77, 1'b0, 1'b1);
        wait_ready("timeout_recover_ready");
        retrieve("timeout_retrieved");

        // Overrun: a character while the frame waits
        exp_q.push_back(16'h2413);
        send_byte(8'h13, 1'b0, 1'b1);
        send_byte(8'h24, 1'b0, 1'b1);
        wait_ready("overrun_ready");
        send_byte(8'h99, 1'b0, 1'b1);
        idle(4);
        check_eq("overrun_err", errs(), 64'b0010);
        check_eq("overrun_data", 64'(DATA), 64'h2413);
        check_eq("overrun_still_ready", 64'(DATA_READY), 64'd1);
        retrieve("overrun_retrieved");
        check_eq("overrun_cleared", errs(), 64'd0);

        // Asynchronous reset in the middle of a character
        send_bit(1'b0);
        send_bit(1'b1);
        RX = 1'b0;
        idle(8);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("async_rst_data", 64'(DATA), 64'd0);
        check_eq("async_rst_ready", 64'(DATA_READY), 64'd0);
        check_eq("async_rst_errs", errs(), 64'd0);
        RX = 1'b1;
        idle(3);
        RST_N = 1'b1;
        idle(5);
        exp_q.push_back(16'h00FF);
        send_byte(8'hFF, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b1);
        wait_ready("after_rst_ready");
        retrieve("after_rst_retrieved");

        idle(5);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
